// File: rtl/ffo_pkg.sv
// Shared types and constants for the sequential find-first-one scanner family.
// The empty/idle index is all-ones, which no valid bit position can reach.
package ffo_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  // Beat fields are sized for any WID up to 65534; the top truncates to IW/CW.
  localparam int BEAT_W = 16;

  typedef struct packed {
    logic [BEAT_W-1:0] idx;
    logic              none;
    logic              last;
    logic [BEAT_W-1:0] cnt;
  } beat_t;

  function automatic int none_idx(input int iw);
    return (1 << iw) - 1;
  endfunction

endpackage

// File: rtl/ffo_n.sv
// Parametrised combinational find-first-one, built as a recursive halving tree.
// Returns the highest (lsb_first=0) or lowest (lsb_first=1) set index, else all-ones.
import ffo_pkg::*;

module ffo_n #(
  parameter int WID = 2,
  parameter int IW  = $clog2(WID + 1)
) (
  input  logic [WID-1:0] vec,
  input  logic           lsb_first,
  output logic [IW-1:0]  idx
);

  localparam logic [IW-1:0] NONE = IW'(none_idx(IW));

  if (WID == 1) begin : g_leaf
    logic unused_lsb;
    assign unused_lsb = lsb_first;
    assign idx        = vec[0] ? '0 : NONE;
  end else begin : g_split
    localparam int LO = WID / 2;
    localparam int HI = WID - LO;

    logic [IW-1:0] lo_idx;
    logic [IW-1:0] hi_idx;
    logic          lo_hit;
    logic          hi_hit;

    // Every sub-tree reports in the full IW width so the all-ones marker survives.
    ffo_n #(.WID(LO), .IW(IW)) u_lo (
      .vec       (vec[LO-1:0]),
      .lsb_first (lsb_first),
      .idx       (lo_idx)
    );

    ffo_n #(.WID(HI), .IW(IW)) u_hi (
      .vec       (vec[WID-1:LO]),
      .lsb_first (lsb_first),
      .idx       (hi_idx)
    );

    assign lo_hit = (lo_idx != NONE);
    assign hi_hit = (hi_idx != NONE);

    always_comb begin
      if (lsb_first) begin
        if (lo_hit)      idx = lo_idx;
        else if (hi_hit) idx = hi_idx + IW'(LO);
        else             idx = NONE;
      end else begin
        if (hi_hit)      idx = hi_idx + IW'(LO);
        else if (lo_hit) idx = lo_idx;
        else             idx = NONE;
      end
    end
  end

endmodule

// File: rtl/ffo_scan.sv
// Sequential bitmap walker: accepts a vector, then emits one beat per set bit
// (or one empty beat) in MSB-first or LSB-first order over a valid/ready output.
import ffo_pkg::*;

module ffo_scan #(
  parameter int WID = 288,
  parameter int IW  = $clog2(WID + 1),
  parameter int CW  = $clog2(WID + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  output logic           i_ready,
  input  logic [WID-1:0] i_vec,
  input  logic           i_lsb_first,
  input  logic           i_abort,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [IW-1:0]  o_idx,
  output logic           o_none,
  output logic           o_last,
  output logic [CW-1:0]  o_cnt,
  output logic           busy
);

  localparam logic [IW-1:0] NONE = IW'(none_idx(IW));

  state_t         state_q, state_d;
  logic [WID-1:0] res_q, res_d;
  logic           mode_q, mode_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [IW-1:0]  found;
  logic [WID-1:0] clr_mask;
  logic           empty;
  logic           last_beat;
  logic           scan;
  logic           xfer;
  logic           load;
  beat_t          beat;
  logic           unused_beat;

  ffo_n #(.WID(WID), .IW(IW)) u_ffo (
    .vec       (res_q),
    .lsb_first (mode_q),
    .idx       (found)
  );

  // An all-ones index matches no position, so the empty beat clears nothing.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < WID; i++) clr_mask[i] = (found == IW'(i));
  end

  assign empty     = (res_q == '0);
  assign last_beat = ((res_q & ~clr_mask) == '0);
  assign scan      = (state_q == ST_SCAN);

  // Reset gates the handshake combinationally so nothing is offered or taken while rst=1.
  assign o_valid = !rst && scan && !i_abort;
  assign xfer    = o_valid && o_ready;
  assign i_ready = !rst && (!scan || (xfer && last_beat));
  assign load    = i_valid && i_ready;
  assign busy    = !rst && scan;

  always_comb begin
    beat     = '0;
    beat.idx = BEAT_W'(NONE);
    if (o_valid) begin
      beat.idx  = BEAT_W'(found);
      beat.none = empty;
      beat.last = last_beat;
      beat.cnt  = BEAT_W'(cnt_q);
    end
  end

  assign o_idx       = beat.idx[IW-1:0];
  assign o_none      = beat.none;
  assign o_last      = beat.last;
  assign o_cnt       = beat.cnt[CW-1:0];
  assign unused_beat = ^beat;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    res_d   = res_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = ST_SCAN;
      res_d   = i_vec;
      mode_d  = i_lsb_first;
      cnt_d   = '0;
    end else if (scan && i_abort) begin
      state_d = ST_IDLE;
      res_d   = '0;
      cnt_d   = '0;
    end else if (xfer) begin
      res_d = res_q & ~clr_mask;
      cnt_d = cnt_q + CW'(1);
      if (last_beat) state_d = ST_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ffo_scan.sv
// Directed bench for ffo_scan: ordering, empty vector, backpressure,
// back-to-back loading, abort and mid-scan reset.
module tb_ffo_scan;

  localparam int WID = 288;
  localparam int IW  = 9;
  localparam int CW  = 9;
  localparam logic [IW-1:0] NONE = 9'h1FF;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_valid;
  logic           i_ready;
  logic [WID-1:0] i_vec;
  logic           i_lsb_first;
  logic           i_abort;
  logic           o_valid;
  logic           o_ready;
  logic [IW-1:0]  o_idx;
  logic           o_none;
  logic           o_last;
  logic [CW-1:0]  o_cnt;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ffo_scan #(.WID(WID)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_vec       (i_vec),
    .i_lsb_first (i_lsb_first),
    .i_abort     (i_abort),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_idx       (o_idx),
    .o_none      (o_none),
    .o_last      (o_last),
    .o_cnt       (o_cnt),
    .busy        (busy)
  );

  // Offer a vector from a negedge in IDLE; returns 1 ns after the accepting edge.
  task automatic drive_load(input logic [WID-1:0] v, input logic lsb);
    i_vec       = v;
    i_lsb_first = lsb;
    i_valid     = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_vec   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({i_ready, o_valid, busy, o_idx, o_none, o_last, o_cnt} !== {1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b v=%b busy=%b idx=%0d none=%b last=%b cnt=%0d, want 0 0 0 511 0 0 0",
               i_ready, o_valid, busy, o_idx, o_none, o_last, o_cnt);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({i_ready, o_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_idle: got rdy=%b v=%b busy=%b, want 1 0 0", i_ready, o_valid, busy);
    end
  endtask

  task automatic test_order(input logic lsb);
    logic [WID-1:0] v;
    int e [4];
    v = '0;
    v[287] = 1'b1; v[144] = 1'b1; v[143] = 1'b1; v[0] = 1'b1;
    if (lsb) e = '{0, 143, 144, 287};
    else     e = '{287, 144, 143, 0};
    o_ready = 1'b1;
    drive_load(v, lsb);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({o_valid, o_idx, o_cnt, o_last, o_none} !== {1'b1, IW'(e[k]), CW'(k), (k == 3), 1'b0}) begin
        n_fail++;
        $display("FAIL order_lsb%0d_beat%0d: got v=%b idx=%0d cnt=%0d last=%b none=%b, want idx=%0d cnt=%0d last=%0d",
                 lsb, k, o_valid, o_idx, o_cnt, o_last, o_none, e[k], k, (k == 3));
      end
    end
    @(negedge clk);
    n_checks++;
    if ({o_valid, busy, i_ready, o_idx} !== {1'b0, 1'b0, 1'b1, NONE}) begin
      n_fail++;
      $display("FAIL order_lsb%0d_done: got v=%b busy=%b rdy=%b idx=%0d, want 0 0 1 511",
               lsb, o_valid, busy, i_ready, o_idx);
    end
  endtask

  task automatic test_empty();
    o_ready = 1'b1;
    drive_load('0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_idx, o_none, o_last, o_cnt} !== {1'b1, NONE, 1'b1, 1'b1, 9'd0}) begin
      n_fail++;
      $display("FAIL empty_beat: got v=%b idx=%0d none=%b last=%b cnt=%0d, want 1 511 1 1 0",
               o_valid, o_idx, o_none, o_last, o_cnt);
    end
    @(negedge clk);
    n_checks++;
    if ({o_valid, i_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL empty_done: got v=%b rdy=%b busy=%b, want 0 1 0", o_valid, i_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [WID-1:0] v;
    v = '0;
    v[5] = 1'b1; v[3] = 1'b1;
    o_ready = 1'b0;
    drive_load(v, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({o_valid, o_idx, o_cnt, o_last} !== {1'b1, 9'd5, 9'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: got v=%b idx=%0d cnt=%0d last=%b, want 1 5 0 0",
                 c, o_valid, o_idx, o_cnt, o_last);
      end
      if (c == 3) o_ready = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_idx, o_cnt, o_last} !== {1'b1, 9'd3, 9'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL backpressure_second: got v=%b idx=%0d cnt=%0d last=%b, want 1 3 1 1",
               o_valid, o_idx, o_cnt, o_last);
    end
    @(negedge clk);
    n_checks++;
    if ({o_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL backpressure_done: got v=%b busy=%b, want 0 0", o_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [WID-1:0] v;
    v = '0;
    v[9] = 1'b1; v[2] = 1'b1;
    o_ready = 1'b1;
    drive_load(v, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_idx, o_cnt, o_last, i_ready} !== {1'b1, 9'd9, 9'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b idx=%0d cnt=%0d last=%b rdy=%b, want 1 9 0 0 0",
               o_valid, o_idx, o_cnt, o_last, i_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_idx, o_cnt, o_last} !== {1'b1, 9'd2, 9'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_last: got v=%b idx=%0d cnt=%0d last=%b, want 1 2 1 1",
               o_valid, o_idx, o_cnt, o_last);
    end
    v = '0;
    v[7] = 1'b1;
    i_vec       = v;
    i_lsb_first = 1'b0;
    i_valid     = 1'b1;
    #1;
    n_checks++;
    if (i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got rdy=%b, want 1", i_ready);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_vec   = '0;
    @(negedge clk);
    n_checks++;
    if ({o_valid, busy, o_idx, o_cnt, o_last} !== {1'b1, 1'b1, 9'd7, 9'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b busy=%b idx=%0d cnt=%0d last=%b, want 1 1 7 0 1",
               o_valid, busy, o_idx, o_cnt, o_last);
    end
    @(negedge clk);
    n_checks++;
    if ({o_valid, i_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_done: got v=%b rdy=%b, want 0 1", o_valid, i_ready);
    end
  endtask

  task automatic test_abort();
    o_ready = 1'b1;
    drive_load({{(WID-8){1'b0}}, 8'hFF}, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({o_valid, o_idx, o_cnt} !== {1'b1, IW'(7 - k), CW'(k)}) begin
        n_fail++;
        $display("FAIL abort_beat%0d: got v=%b idx=%0d cnt=%0d, want 1 %0d %0d",
                 k, o_valid, o_idx, o_cnt, 7 - k, k);
      end
    end
    @(negedge clk);
    i_abort = 1'b1;
    #1;
    n_checks++;
    if ({o_valid, i_ready, o_idx} !== {1'b0, 1'b0, NONE}) begin
      n_fail++;
      $display("FAIL abort_cycle: got v=%b rdy=%b idx=%0d, want 0 0 511", o_valid, i_ready, o_idx);
    end
    @(posedge clk);
    #1;
    i_abort = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({o_valid, busy, i_ready, o_idx} !== {1'b0, 1'b0, 1'b1, NONE}) begin
        n_fail++;
        $display("FAIL abort_after%0d: got v=%b busy=%b rdy=%b idx=%0d, want 0 0 1 511",
                 c, o_valid, busy, i_ready, o_idx);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [WID-1:0] v;
    o_ready = 1'b1;
    drive_load({{(WID-8){1'b0}}, 8'hFF}, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_idx, o_cnt} !== {1'b1, 9'd6, 9'd1}) begin
      n_fail++;
      $display("FAIL rstmid_beat1: got v=%b idx=%0d cnt=%0d, want 1 6 1", o_valid, o_idx, o_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if ({i_ready, o_valid, busy, o_idx, o_none, o_last, o_cnt} !== {1'b0, 1'b0, 1'b0, NONE, 1'b0, 1'b0, 9'd0}) begin
        n_fail++;
        $display("FAIL rstmid_hold%0d: got rdy=%b v=%b busy=%b idx=%0d none=%b last=%b cnt=%0d, want 0 0 0 511 0 0 0",
                 c, i_ready, o_valid, busy, o_idx, o_none, o_last, o_cnt);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({i_ready, o_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL rstmid_idle: got rdy=%b v=%b busy=%b, want 1 0 0", i_ready, o_valid, busy);
    end
    v = '0;
    v[4] = 1'b1;
    drive_load(v, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_idx, o_cnt, o_last} !== {1'b1, 9'd4, 9'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_reload: got v=%b idx=%0d cnt=%0d last=%b, want 1 4 0 1",
               o_valid, o_idx, o_cnt, o_last);
    end
    @(negedge clk);
    n_checks++;
    if ({o_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_done: got v=%b busy=%b, want 0 0", o_valid, busy);
    end
  endtask

  initial begin
    rst         = 1'b1;
    i_valid     = 1'b0;
    i_vec       = '0;
    i_lsb_first = 1'b0;
    i_abort     = 1'b0;
    o_ready     = 1'b0;
    test_reset();
    test_order(1'b0);
    test_order(1'b1);
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want completion");
    $fatal(1, "watchdog");
  end

endmodule
